traffic_light_timed: RTL and testbench

Parametrised successor to the single-step traffic-light sequencer: one-clock, fully synchronous controller for a main/side intersection with per-phase tick-counted durations. Adds a two-phase pedestrian crossing (walk, then flashing clear), an optional side-street demand mode, and a flashing night mode. It sits between the board tick generator (`en` pulses) and the lamp drivers, and replaces the asynchronous pedestrian latch with a registered request.

---
 rtl/traffic_light_timed.sv | 143 ++++++++++++++
 tb/tb_traffic_light_timed.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_timed.sv
// Timed main/side intersection sequencer with a two-phase pedestrian crossing,
// optional side-street demand mode and flashing night mode. All lamps decode registered state.
module traffic_light_timed #(
  parameter int CNT_W          = 8,
  parameter int GREEN_TICKS    = 20,
  parameter int YELLOW_TICKS   = 4,
  parameter int ALLRED_TICKS   = 2,
  parameter int WALK_TICKS     = 10,
  parameter int CLEAR_TICKS    = 6,
  parameter int SIDE_ON_DEMAND = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pedToggle,
  input  logic             sideReq,
  input  logic             flashMode,
  output logic             MG,
  output logic             MY,
  output logic             MR,
  output logic             SG,
  output logic             SY,
  output logic             SR,
  output logic             pedWalk,
  output logic             pedDontWalk,
  output logic             pedWait,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [3:0] {
    S_MAIN_G, S_MAIN_Y, S_ALLRED1, S_SIDE_G, S_SIDE_Y,
    S_ALLRED2, S_PED_WALK, S_PED_CLEAR, S_FLASH
  } state_t;

  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] W_LD  = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] C_LD  = CNT_W'(CLEAR_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pedWait_q, pedWait_d;
  logic             side_q, side_d;
  logic             flash_q, flash_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_MAIN_G;
      timer_q   <= G_LD;
      pedWait_q <= 1'b0;
      side_q    <= 1'b0;
      flash_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pedWait_q <= pedWait_d;
      side_q    <= side_d;
      flash_q   <= flash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    if (en) begin
      if (state_q == S_FLASH) begin
        if (!flashMode) begin
          state_d = S_ALLRED2;
          timer_d = AR_LD;
          flash_d = 1'b0;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
        if (state_q == S_PED_CLEAR) flash_d = ~flash_q;
      end else begin
        case (state_q)
          S_MAIN_G: begin
            // Demand mode parks at timer 0 until someone is waiting.
            if (SIDE_ON_DEMAND == 0 || side_q || pedWait_q) begin
              state_d = S_MAIN_Y;
              timer_d = Y_LD;
            end
          end
          S_MAIN_Y: begin state_d = S_ALLRED1; timer_d = AR_LD; end
          S_ALLRED1: begin
            if (flashMode) begin
              state_d = S_FLASH; timer_d = '0; flash_d = 1'b1;
            end else begin
              state_d = S_SIDE_G; timer_d = G_LD;
            end
          end
          S_SIDE_G: begin state_d = S_SIDE_Y;  timer_d = Y_LD;  end
          S_SIDE_Y: begin state_d = S_ALLRED2; timer_d = AR_LD; end
          S_ALLRED2: begin
            if (flashMode) begin
              state_d = S_FLASH; timer_d = '0; flash_d = 1'b1;
            end else if (pedWait_q) begin
              state_d = S_PED_WALK; timer_d = W_LD;
            end else begin
              state_d = S_MAIN_G; timer_d = G_LD;
            end
          end
          S_PED_WALK: begin state_d = S_PED_CLEAR; timer_d = C_LD; flash_d = 1'b1; end
          S_PED_CLEAR: begin state_d = S_MAIN_G; timer_d = G_LD; flash_d = 1'b0; end
          default: begin state_d = S_MAIN_G; timer_d = G_LD; flash_d = 1'b0; end
        endcase
      end
    end
  end

  // Request flags sample every clk; the clear on phase entry beats a same-edge set.
  always_comb begin
    pedWait_d = pedWait_q | (pedToggle && state_q != S_PED_WALK);
    if (state_d == S_PED_WALK && state_q != S_PED_WALK) pedWait_d = 1'b0;
    side_d = side_q | sideReq;
    if (state_d == S_SIDE_G && state_q != S_SIDE_G) side_d = 1'b0;
  end

  always_comb begin
    MG = 1'b0; MY = 1'b0; MR = 1'b0;
    SG = 1'b0; SY = 1'b0; SR = 1'b0;
    pedWalk     = 1'b0;
    pedDontWalk = 1'b1;
    case (state_q)
      S_MAIN_G:    begin MG = 1'b1; SR = 1'b1; end
      S_MAIN_Y:    begin MY = 1'b1; SR = 1'b1; end
      S_SIDE_G:    begin MR = 1'b1; SG = 1'b1; end
      S_SIDE_Y:    begin MR = 1'b1; SY = 1'b1; end
      S_PED_WALK:  begin MR = 1'b1; SR = 1'b1; pedWalk = 1'b1; pedDontWalk = 1'b0; end
      S_PED_CLEAR: begin MR = 1'b1; SR = 1'b1; pedDontWalk = flash_q; end
      S_FLASH:     begin MY = flash_q; SR = flash_q; end
      default:     begin MR = 1'b1; SR = 1'b1; end
    endcase
  end

  assign pedWait   = pedWait_q;
  assign remaining = timer_q;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed bench for traffic_light_timed: short phase durations, one free-running
// instance and one in side-on-demand mode sharing the same stimulus.
module tb_traffic_light_timed;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic pedToggle = 1'b0;
  logic sideReq = 1'b0;
  logic flashMode = 1'b0;

  logic MG, MY, MR, SG, SY, SR, pedWalk, pedDontWalk, pedWait;
  logic [7:0] remaining;
  logic MG2, MY2, MR2, SG2, SY2, SR2, pedWalk2, pedDontWalk2, pedWait2;
  logic [7:0] remaining2;

  int vectors = 0;
  int miscompares = 0;

  // Lamp patterns {MG,MY,MR,SG,SY,SR,pedWalk,pedDontWalk}
  localparam logic [7:0] LMG = 8'b1000_0101;
  localparam logic [7:0] LMY = 8'b0100_0101;
  localparam logic [7:0] LAR = 8'b0010_0101;
  localparam logic [7:0] LSG = 8'b0011_0001;
  localparam logic [7:0] LSY = 8'b0010_1001;
  localparam logic [7:0] LPW = 8'b0010_0110;
  localparam logic [7:0] LPC1 = 8'b0010_0101;
  localparam logic [7:0] LPC0 = 8'b0010_0100;
  localparam logic [7:0] LF1 = 8'b0100_0101;
  localparam logic [7:0] LF0 = 8'b0000_0001;

  traffic_light_timed #(.CNT_W(8), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1),
    .WALK_TICKS(2), .CLEAR_TICKS(2), .SIDE_ON_DEMAND(0)) dut (
    .clk(clk), .reset(reset), .en(en), .pedToggle(pedToggle), .sideReq(sideReq),
    .flashMode(flashMode), .MG(MG), .MY(MY), .MR(MR), .SG(SG), .SY(SY), .SR(SR),
    .pedWalk(pedWalk), .pedDontWalk(pedDontWalk), .pedWait(pedWait), .remaining(remaining));

  traffic_light_timed #(.CNT_W(8), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1),
    .WALK_TICKS(2), .CLEAR_TICKS(2), .SIDE_ON_DEMAND(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .pedToggle(pedToggle), .sideReq(sideReq),
    .flashMode(flashMode), .MG(MG2), .MY(MY2), .MR(MR2), .SG(SG2), .SY(SY2), .SR(SR2),
    .pedWalk(pedWalk2), .pedDontWalk(pedDontWalk2), .pedWait(pedWait2), .remaining(remaining2));

  always #5 clk = ~clk;

  logic [16:0] o1, o2;
  assign o1 = {MG, MY, MR, SG, SY, SR, pedWalk, pedDontWalk, pedWait, remaining};
  assign o2 = {MG2, MY2, MR2, SG2, SY2, SR2, pedWalk2, pedDontWalk2, pedWait2, remaining2};

  task automatic chk(input string tag, input logic [16:0] obs, input logic [7:0] l,
                     input logic pw, input logic [7:0] rem);
    logic [16:0] e;
    e = {l, pw, rem};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic st(input string tag, input logic [7:0] l, input logic pw, input logic [7:0] rem);
    @(posedge clk); #1;
    chk(tag, o1, l, pw, rem);
  endtask

  task automatic st2(input string tag, input logic [7:0] l, input logic pw, input logic [7:0] rem);
    @(posedge clk); #1;
    chk(tag, o2, l, pw, rem);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_async", o1, LMG, 1'b0, 8'd2);
    chk("rst_async2", o2, LMG, 1'b0, 8'd2);
    @(posedge clk); #1;
    chk("rst_held", o1, LMG, 1'b0, 8'd2);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // Basic cycle with no requests
    do_reset();
    st("t1_mg1", LMG, 0, 1);  st("t1_mg0", LMG, 0, 0);
    st("t1_my1", LMY, 0, 1);  st("t1_my0", LMY, 0, 0);
    st("t1_ar1", LAR, 0, 0);
    st("t1_sg2", LSG, 0, 2);  st("t1_sg1", LSG, 0, 1);  st("t1_sg0", LSG, 0, 0);
    st("t1_sy1", LSY, 0, 1);  st("t1_sy0", LSY, 0, 0);
    st("t1_ar2", LAR, 0, 0);
    st("t1_mg2", LMG, 0, 2);

    // Pedestrian request during side green
    st("t2_mg1", LMG, 0, 1);  st("t2_mg0", LMG, 0, 0);
    st("t2_my1", LMY, 0, 1);  st("t2_my0", LMY, 0, 0);
    st("t2_ar1", LAR, 0, 0);  st("t2_sg2", LSG, 0, 2);
    pedToggle = 1'b1;
    st("t2_sg1_pw", LSG, 1, 1);
    pedToggle = 1'b0;
    st("t2_sg0", LSG, 1, 0);
    st("t2_sy1", LSY, 1, 1);  st("t2_sy0", LSY, 1, 0);
    st("t2_ar2", LAR, 1, 0);
    st("t2_walk1", LPW, 0, 1);  st("t2_walk0", LPW, 0, 0);
    st("t2_clr1", LPC1, 0, 1);  st("t2_clr0", LPC0, 0, 0);
    st("t2_mg2", LMG, 0, 2);

    // Sparse ticks; press between ticks is captured
    en = 1'b0;
    do_reset();
    st("t3_idle_a", LMG, 0, 2);
    pedToggle = 1'b1;
    st("t3_idle_press", LMG, 1, 2);
    pedToggle = 1'b0;
    st("t3_idle_c", LMG, 1, 2);
    en = 1'b1;
    st("t3_tick1", LMG, 1, 1);
    en = 1'b0;
    st("t3_hold_a", LMG, 1, 1);  st("t3_hold_b", LMG, 1, 1);  st("t3_hold_c", LMG, 1, 1);
    en = 1'b1;
    st("t3_tick2", LMG, 1, 0);

    // Side-on-demand instance parks at main green
    do_reset();
    st2("t4_mg1", LMG, 0, 1);  st2("t4_mg0", LMG, 0, 0);
    for (int i = 0; i < 50; i++) st2("t4_park", LMG, 0, 0);
    sideReq = 1'b1;
    st2("t4_req", LMG, 0, 0);
    sideReq = 1'b0;
    st2("t4_my1", LMY, 0, 1);  st2("t4_my0", LMY, 0, 0);
    st2("t4_ar1", LAR, 0, 0);
    st2("t4_sg2", LSG, 0, 2);  st2("t4_sg1", LSG, 0, 1);  st2("t4_sg0", LSG, 0, 0);
    st2("t4_sy1", LSY, 0, 1);  st2("t4_sy0", LSY, 0, 0);  st2("t4_ar2", LAR, 0, 0);
    st2("t4_mg2", LMG, 0, 2);  st2("t4_mgb1", LMG, 0, 1);  st2("t4_mgb0", LMG, 0, 0);
    st2("t4_repark", LMG, 0, 0);

    // Flash wins over pending pedestrian at ALLRED2
    do_reset();
    st("t5_mg1", LMG, 0, 1);  st("t5_mg0", LMG, 0, 0);
    st("t5_my1", LMY, 0, 1);  st("t5_my0", LMY, 0, 0);
    st("t5_ar1", LAR, 0, 0);  st("t5_sg2", LSG, 0, 2);
    pedToggle = 1'b1;
    flashMode = 1'b1;
    st("t5_sg1", LSG, 1, 1);
    pedToggle = 1'b0;
    st("t5_sg0", LSG, 1, 0);
    st("t5_sy1", LSY, 1, 1);  st("t5_sy0", LSY, 1, 0);
    st("t5_ar2", LAR, 1, 0);
    st("t5_fl_1a", LF1, 1, 0);  st("t5_fl_0", LF0, 1, 0);  st("t5_fl_1b", LF1, 1, 0);
    flashMode = 1'b0;
    st("t5_ar2_back", LAR, 1, 0);
    st("t5_walk1", LPW, 0, 1);
    pedToggle = 1'b1;
    st("t5_walk_press_ign", LPW, 0, 0);
    pedToggle = 1'b0;
    st("t5_clr1", LPC1, 0, 1);
    pedToggle = 1'b1;
    st("t5_clr0_pw", LPC0, 1, 0);
    pedToggle = 1'b0;

    // Asynchronous reset mid-cycle during PED_CLEAR with a pending request
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_rst", o1, LMG, 1'b0, 8'd2);
    @(posedge clk); #1;
    chk("t6_rst_held", o1, LMG, 1'b0, 8'd2);
    reset = 1'b0;
    st("t6_after", LMG, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
